// File: rtl/instr_seq_responder.sv
// -----------------------------------------------------------------------------
// instr_seq_responder
//   Host-side instruction sequencer for the TPU core. The front end loads a
//   DEPTH-entry instruction buffer while the sequencer is idle, then pulses
//   start_execution. The sequencer walks the buffer from address 0 and
//   presents each word to the core controller over a valid/ready handshake.
//   It stops at a HALT opcode, which is not issued, or after the last entry.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   instr_wr_en       buffer write strobe. Honoured only while idle.
//   instr_wr_addr     buffer write address
//   instr_wr_data     instruction word. The opcode is in bits [25:22].
//   start_execution   single-cycle start pulse. Honoured only while idle.
//   issue_valid       issue_instr/issue_pc carry an instruction
//   issue_ready       core controller accepts the instruction
//   issue_instr       instruction being issued
//   issue_pc          buffer address of the issued instruction. Holds the
//                     last accepted address when no instruction is valid.
//   seq_busy          sequencer active (FETCH, ISSUE, FINISH)
//   seq_done          one-cycle pulse at program end
//   issued_count      handshakes completed in the current or last run
//   wr_reject         one-cycle pulse after a write was dropped
// -----------------------------------------------------------------------------
module instr_seq_responder #(
  parameter int           DEPTH       = 32,
  parameter int           ADDR_W      = 5,
  parameter int           DATA_W      = 32,
  parameter logic [3:0]   HALT_OPCODE = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_wr_en,
  input  logic [ADDR_W-1:0] instr_wr_addr,
  input  logic [DATA_W-1:0] instr_wr_data,
  input  logic              start_execution,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [DATA_W-1:0] issue_instr,
  output logic [ADDR_W-1:0] issue_pc,
  output logic              seq_busy,
  output logic              seq_done,
  output logic [ADDR_W:0]   issued_count,
  output logic              wr_reject
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_FINISH} state_e;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_reject_q, wr_reject_d;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              is_halt;

  assign is_halt = (word_q[25:22] == HALT_OPCODE);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    last_pc_d   = last_pc_q;
    count_d     = count_q;
    issue_valid = 1'b0;
    wr_reject_d = instr_wr_en && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start_execution) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          last_pc_d = '0;
          count_d   = '0;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        if (is_halt) begin
          state_d = S_FINISH;
        end else begin
          issue_valid = 1'b1;
          if (issue_ready) begin
            count_d   = count_q + 1'b1;
            last_pc_d = pc_q;
            // The last entry ends the program. The pc never wraps to 0.
            if (pc_q == LAST_PC) begin
              state_d = S_FINISH;
            end else begin
              pc_d    = pc_q + 1'b1;
              state_d = S_FETCH;
            end
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      last_pc_q   <= '0;
      count_q     <= '0;
      wr_reject_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      last_pc_q   <= last_pc_d;
      count_q     <= count_d;
      wr_reject_q <= wr_reject_d;
    end
  end

  // The buffer and its read register have no reset, so the program survives
  // rst. A write that arrives with start is committed before FETCH reads it.
  always_ff @(posedge clk) begin
    if (instr_wr_en && (state_q == S_IDLE)) begin
      mem[instr_wr_addr] <= instr_wr_data;
    end
    if (state_q == S_FETCH) begin
      word_q <= mem[pc_q];
    end
  end

  // The instruction output is forced to zero when it is not valid. This keeps
  // the unreset read register from ever reaching the port.
  assign issue_instr  = issue_valid ? word_q : '0;
  assign issue_pc     = issue_valid ? pc_q : last_pc_q;
  assign seq_busy     = (state_q != S_IDLE);
  assign seq_done     = (state_q == S_FINISH);
  assign issued_count = count_q;
  assign wr_reject    = wr_reject_q;

endmodule

// File: tb/tb_instr_seq_responder.sv
module tb_instr_seq_responder;

  localparam logic [31:0] OP1_W  = 32'h0040_0000;
  localparam logic [31:0] OP2_W  = 32'h0080_0000;
  localparam logic [31:0] HALT_W = 32'h03C0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_wr_en = 1'b0;
  logic [4:0]  instr_wr_addr = '0;
  logic [31:0] instr_wr_data = '0;
  logic        start_execution = 1'b0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [31:0] issue_instr;
  logic [4:0]  issue_pc;
  logic        seq_busy;
  logic        seq_done;
  logic [5:0]  issued_count;
  logic        wr_reject;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations gathered by run_prog; compared inside each test task.
  logic [31:0] iss_instr[$];
  logic [4:0]  iss_pc[$];
  int done_pulses, unstable, first_valid_cycles, cyc_first_valid, cyc_done;
  int rej_cnt, rej_cyc;
  bit timed_out, aborted;

  instr_seq_responder dut (
    .clk(clk), .rst(rst),
    .instr_wr_en(instr_wr_en), .instr_wr_addr(instr_wr_addr),
    .instr_wr_data(instr_wr_data), .start_execution(start_execution),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_pc(issue_pc),
    .seq_busy(seq_busy), .seq_done(seq_done),
    .issued_count(issued_count), .wr_reject(wr_reject)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [4:0] a, input logic [31:0] d);
    instr_wr_en = 1'b1; instr_wr_addr = a; instr_wr_data = d;
    tick;
    instr_wr_en = 1'b0;
  endtask

  // Starts a run and records the run cycle by cycle. Cycle 1 is the first
  // sample after the start edge.
  task automatic run_prog(input int hold_low, input int inj_cyc, input int abort_pc,
                          input bit wr0_halt, input int max_cyc);
    int cyc, low_left;
    bit pv, pr;
    logic [31:0] pi;
    logic [4:0]  pp;
    iss_instr.delete(); iss_pc.delete();
    done_pulses = 0; unstable = 0; first_valid_cycles = 0;
    cyc_first_valid = -1; cyc_done = -1; rej_cnt = 0; rej_cyc = -1;
    timed_out = 0; aborted = 0;
    low_left = hold_low; pv = 0; pr = 0; pi = '0; pp = '0;
    if (wr0_halt) begin
      instr_wr_en = 1'b1; instr_wr_addr = 5'd0; instr_wr_data = HALT_W;
    end
    start_execution = 1'b1;
    issue_ready = (hold_low == 0);
    cyc = 0;
    forever begin
      tick; cyc++;
      start_execution = 1'b0; instr_wr_en = 1'b0;
      if (seq_done) begin done_pulses++; if (cyc_done < 0) cyc_done = cyc; end
      if (wr_reject) begin rej_cnt++; if (rej_cyc < 0) rej_cyc = cyc; end
      if (issue_valid) begin
        if (cyc_first_valid < 0) cyc_first_valid = cyc;
        if (iss_pc.size() == 0) first_valid_cycles++;
        if (pv && !pr && (issue_instr !== pi || issue_pc !== pp)) unstable++;
        if (abort_pc >= 0 && issue_pc == 5'(abort_pc)) begin
          rst = 1'b1; issue_ready = 1'b1; aborted = 1;
          break;
        end
        if (low_left > 0) begin low_left--; issue_ready = 1'b0; end
        else issue_ready = 1'b1;
        if (issue_ready) begin iss_instr.push_back(issue_instr); iss_pc.push_back(issue_pc); end
      end
      pv = issue_valid; pr = issue_ready; pi = issue_instr; pp = issue_pc;
      if (cyc == inj_cyc) begin
        instr_wr_en = 1'b1; instr_wr_addr = 5'd5; instr_wr_data = 32'hFFFF_FFFF;
        start_execution = 1'b1;
      end
      if (!seq_busy) break;
      if (cyc >= max_cyc) begin timed_out = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    n_cmp++; if ({issue_valid, seq_busy, seq_done, wr_reject} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000", {issue_valid, seq_busy, seq_done, wr_reject}); end
    n_cmp++; if (issue_instr !== 32'h0 || issue_pc !== 5'd0 || issued_count !== 6'd0) begin
      n_bad++; $display("FAIL reset_data got instr=%h pc=%0d cnt=%0d want 0", issue_instr, issue_pc, issued_count); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    write_word(5'd0, OP1_W); write_word(5'd1, OP2_W); write_word(5'd2, HALT_W);
    run_prog(0, -1, -1, 0, 200);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL basic_timeout got 1 want 0"); end
    n_cmp++; if (cyc_first_valid !== 2) begin n_bad++; $display("FAIL basic_latency got %0d want 2", cyc_first_valid); end
    n_cmp++; if (iss_instr.size() !== 2) begin n_bad++; $display("FAIL basic_nissue got %0d want 2", iss_instr.size()); end
    else begin
      n_cmp++; if (iss_instr[0] !== OP1_W || iss_pc[0] !== 5'd0) begin
        n_bad++; $display("FAIL basic_issue0 got %h@%0d want %h@0", iss_instr[0], iss_pc[0], OP1_W); end
      n_cmp++; if (iss_instr[1] !== OP2_W || iss_pc[1] !== 5'd1) begin
        n_bad++; $display("FAIL basic_issue1 got %h@%0d want %h@1", iss_instr[1], iss_pc[1], OP2_W); end
    end
    n_cmp++; if (done_pulses !== 1 || cyc_done !== 7) begin
      n_bad++; $display("FAIL basic_done got n=%0d at %0d want n=1 at 7", done_pulses, cyc_done); end
    n_cmp++; if (issued_count !== 6'd2) begin n_bad++; $display("FAIL basic_count got %0d want 2", issued_count); end
    n_cmp++; if (seq_busy !== 1'b0 || issue_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_idle got busy=%b valid=%b want 0 0", seq_busy, issue_valid); end
    n_cmp++; if (issue_pc !== 5'd1) begin n_bad++; $display("FAIL basic_pc_hold got %0d want 1", issue_pc); end
    tick;
  endtask

  task automatic test_backpressure;
    run_prog(5, -1, -1, 0, 200);
    n_cmp++; if (first_valid_cycles !== 6) begin
      n_bad++; $display("FAIL bp_valid_cycles got %0d want 6", first_valid_cycles); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
    n_cmp++; if (iss_instr.size() !== 2 || issued_count !== 6'd2) begin
      n_bad++; $display("FAIL bp_count got n=%0d cnt=%0d want 2 2", iss_instr.size(), issued_count); end
    n_cmp++; if (cyc_done !== 12) begin n_bad++; $display("FAIL bp_done_cyc got %0d want 12", cyc_done); end
    tick;
  endtask

  task automatic test_full_buffer;
    int pc_bad;
    for (int i = 0; i < 32; i++) write_word(5'(i), OP1_W | 32'(i));
    run_prog(0, -1, -1, 0, 300);
    pc_bad = 0;
    foreach (iss_pc[i]) if (iss_pc[i] !== 5'(i) || iss_instr[i] !== (OP1_W | 32'(i))) pc_bad++;
    n_cmp++; if (iss_pc.size() !== 32 || pc_bad !== 0) begin
      n_bad++; $display("FAIL full_seq got n=%0d bad=%0d want 32 0", iss_pc.size(), pc_bad); end
    n_cmp++; if (issued_count !== 6'd32) begin n_bad++; $display("FAIL full_count got %0d want 32", issued_count); end
    n_cmp++; if (cyc_done !== 65 || done_pulses !== 1) begin
      n_bad++; $display("FAIL full_done got n=%0d at %0d want 1 at 65", done_pulses, cyc_done); end
    tick;
  endtask

  task automatic test_busy_write_restart;
    int pc_bad;
    run_prog(0, 10, -1, 0, 300);
    n_cmp++; if (rej_cnt !== 1 || rej_cyc !== 11) begin
      n_bad++; $display("FAIL rej_pulse got n=%0d at %0d want 1 at 11", rej_cnt, rej_cyc); end
    pc_bad = 0;
    foreach (iss_pc[i]) if (iss_pc[i] !== 5'(i)) pc_bad++;
    n_cmp++; if (iss_pc.size() !== 32 || pc_bad !== 0 || issued_count !== 6'd32) begin
      n_bad++; $display("FAIL restart_ignored got n=%0d bad=%0d cnt=%0d want 32 0 32", iss_pc.size(), pc_bad, issued_count); end
    n_cmp++; if (done_pulses !== 1) begin n_bad++; $display("FAIL restart_done got %0d want 1", done_pulses); end
    tick;
    run_prog(0, -1, -1, 0, 300);
    n_cmp++; if (iss_instr.size() !== 32) begin n_bad++; $display("FAIL mem5_run got n=%0d want 32", iss_instr.size()); end
    else begin
      n_cmp++; if (iss_instr[5] !== (OP1_W | 32'd5)) begin
        n_bad++; $display("FAIL mem5_kept got %h want %h", iss_instr[5], OP1_W | 32'd5); end
    end
    tick;
  endtask

  task automatic test_reset_midrun;
    int bad;
    write_word(5'd6, HALT_W);
    run_prog(0, -1, 3, 0, 300);
    n_cmp++; if (aborted !== 1'b1 || iss_pc.size() !== 3) begin
      n_bad++; $display("FAIL abort_reach got ab=%0b n=%0d want 1 3", aborted, iss_pc.size()); end
    tick;
    n_cmp++; if ({issue_valid, seq_busy, seq_done, wr_reject} !== 4'b0) begin
      n_bad++; $display("FAIL abort_flags got %b want 0000", {issue_valid, seq_busy, seq_done, wr_reject}); end
    n_cmp++; if (issue_instr !== 32'h0 || issue_pc !== 5'd0 || issued_count !== 6'd0) begin
      n_bad++; $display("FAIL abort_data got instr=%h pc=%0d cnt=%0d want 0", issue_instr, issue_pc, issued_count); end
    rst = 1'b0;
    tick;
    n_cmp++; if (seq_done !== 1'b0 || seq_busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_nodone got done=%b busy=%b want 0 0", seq_done, seq_busy); end
    run_prog(0, -1, -1, 0, 300);
    bad = 0;
    foreach (iss_pc[i]) if (iss_pc[i] !== 5'(i) || iss_instr[i] !== (OP1_W | 32'(i))) bad++;
    n_cmp++; if (iss_pc.size() !== 6 || bad !== 0 || issued_count !== 6'd6) begin
      n_bad++; $display("FAIL replay got n=%0d bad=%0d cnt=%0d want 6 0 6", iss_pc.size(), bad, issued_count); end
    tick;
  endtask

  task automatic test_write_with_start;
    run_prog(0, -1, -1, 1, 100);
    n_cmp++; if (cyc_first_valid !== -1) begin
      n_bad++; $display("FAIL wstart_novalid got valid at %0d want none", cyc_first_valid); end
    n_cmp++; if (cyc_done !== 3 || done_pulses !== 1) begin
      n_bad++; $display("FAIL wstart_done got n=%0d at %0d want 1 at 3", done_pulses, cyc_done); end
    n_cmp++; if (issued_count !== 6'd0) begin n_bad++; $display("FAIL wstart_count got %0d want 0", issued_count); end
    n_cmp++; if (rej_cnt !== 0) begin n_bad++; $display("FAIL wstart_reject got %0d want 0", rej_cnt); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_full_buffer;
    test_busy_write_restart;
    test_reset_midrun;
    test_write_with_start;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
